seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
Monitors the multiplexed seven-segment bus (active-low segment byte plus active-low anode select) and reconstructs the 4-digit BCD value being displayed. Used for on-board self-test and bench loopback of the score display path. Samples each digit only after the bus has settled, then publishes a complete 16-bit frame once all four digit positions have been captured.

Parameters:
STABLE_CYCLES, 4, consecutive identical registered samples of {an, segment} required before a digit is captured (legal range 2..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
segment  input  8  active-low segment byte, bit7 = dp (ignored), bits6:0 = g..a
an  input  4  active-low anode select; an[i]=0 selects digit i (digit 0 = value[3:0])
clr_err  input  1  synchronous clear of code_err
value  output  16  last complete frame, digit i in value[4i+3:4i]
digit_seen  output  4  digit positions captured in the current, incomplete frame
frame_valid  output  1  one-cycle pulse when value updates
code_err  output  1  sticky flag: an unrecognised segment code was captured

Behaviour:
- Reset values: value=16'h0000, digit_seen=4'b0000, frame_valid=0, code_err=0, stable counter=0, captured flag=0, sample registers an_q=4'hF, seg_q=8'hFF.
- Input stage: {an, segment} registered into {an_q, seg_q} every cycle. All decisions use the registered copy.
- Select validity: an_q must have exactly one zero bit. Any other pattern (4'hF, two or more zeros) means no selection: counter cleared, captured flag cleared, no capture.
- Stability: if {an_q, seg_q} equals the previous cycle's {an_q, seg_q}, the counter increments and saturates at STABLE_CYCLES-1. Otherwise it resets to 0 and the captured flag clears.
- Capture: occurs in the cycle the counter reaches STABLE_CYCLES-1 with the captured flag clear. The flag is then set, so a held pattern captures once only. A capture is therefore registered STABLE_CYCLES+1 clocks after the pattern first appears at the pins.
- Decode of seg_q[6:0] (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code: store nibble 4'hF and set code_err.
- On capture of digit i: shadow nibble i is written and digit_seen[i] is set. Re-capturing an already-seen position overwrites its nibble.
- Frame completion: in the cycle digit_seen would become 4'b1111 (including the current capture):
  - value is loaded with the shadow including the new nibble;
  - frame_valid=1 for exactly that cycle;
  - digit_seen clears to 4'b0000.
- code_err: set on an invalid capture, cleared by clr_err. If both occur in the same cycle, set wins.
- Reset mid-frame: the shadow and digit_seen are discarded. value returns to 0 and holds until a full new frame arrives.

Optional Feature:
SEG_DEC_HEX_EN
- Defined: these codes also decode as valid digits, with no code_err: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Undefined: A-F codes are invalid (nibble 4'hF, code_err set).

Decomposition:
- Shared package seg_pkg:
  - SEG_* localparams for the 7-bit active-low codes (0-9, A-F, BLANK=7'h7F);
  - NUM_DIGITS=4;
  - a function seg_to_nibble returning {ok, nibble}, with the hex entries inside the SEG_DEC_HEX_EN guard.
- One sub-module, seg_settle: the input registers, one-hot check, stability counter and captured flag. It outputs capture_stb, the digit index and seg_q.
- The top level holds the decode, shadow register, frame assembly and error flag.

Test Plan:
- Score 16'h1234, each anode held 8 cycles, STABLE_CYCLES=4, order 0..3: frame_valid pulses once after digit 3 is captured, value=16'h1234, digit_seen returns to 0.
- Anode held only 3 cycles per digit: no capture, digit_seen stays 0, frame_valid never asserts.
- Digit 2 driven with 8'hFF (blank): code_err=1 and value=16'h1F34 at frame end. Then clr_err pulse with no new error: code_err=0. Then clr_err in the same cycle as a new invalid capture: code_err stays 1.
- an=4'b1100 held 20 cycles, then an=4'b1111 held 20 cycles: no captures. Digit 0 held 50 cycles: exactly one capture (digit_seen=0001).
- Reset asserted asynchronously after digits 0 and 1 are captured: all outputs return to reset values immediately. A full 16'h5678 scan afterwards yields value=16'h5678.
- With SEG_DEC_HEX_EN defined, scanning codes for 16'hABCD: value=16'hABCD, code_err=0. The same stimulus without the macro gives value=16'hFFFF, code_err=1.

Source files
------------

// File: rtl/seg_pkg.sv
// Seven-segment code table (active-low, bit6..0 = g..a) and the code-to-nibble decoder.
// Define SEG_DEC_HEX_EN to accept A-F glyphs as valid digits.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Returns {ok, nibble}; unknown glyphs (including blank) give {0, 4'hF}.
  function automatic logic [4:0] seg_to_nibble(input logic [6:0] code);
    logic [4:0] r;
    r = {1'b0, 4'hF};
    case (code)
      SEG_0: r = {1'b1, 4'h0};
      SEG_1: r = {1'b1, 4'h1};
      SEG_2: r = {1'b1, 4'h2};
      SEG_3: r = {1'b1, 4'h3};
      SEG_4: r = {1'b1, 4'h4};
      SEG_5: r = {1'b1, 4'h5};
      SEG_6: r = {1'b1, 4'h6};
      SEG_7: r = {1'b1, 4'h7};
      SEG_8: r = {1'b1, 4'h8};
      SEG_9: r = {1'b1, 4'h9};
`ifdef SEG_DEC_HEX_EN
      SEG_A: r = {1'b1, 4'hA};
      SEG_B: r = {1'b1, 4'hB};
      SEG_C: r = {1'b1, 4'hC};
      SEG_D: r = {1'b1, 4'hD};
      SEG_E: r = {1'b1, 4'hE};
      SEG_F: r = {1'b1, 4'hF};
`endif
      SEG_BLANK: r = {1'b0, 4'hF};
      default:   r = {1'b0, 4'hF};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_settle.sv
// Registers the scan bus, checks for a single active anode and waits for the bus to hold still.
// Emits a one-cycle capture strobe once per settled {anode, segment} pattern.
module seg_settle #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] segment_i,
  input  logic [3:0] an_i,
  output logic       capture_o,
  output logic [1:0] digit_idx_o,
  output logic [6:0] seg_o
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [3:0] an_q, an_p_q;
  logic [7:0] seg_q, seg_p_q;
  logic [7:0] cnt_q, cnt_d;
  logic       captured_q, captured_d;
  logic       sel_ok, same;
  logic [1:0] idx;

  always_comb begin
    sel_ok     = ($countones(~an_q) == 1);
    same       = ({an_q, seg_q} == {an_p_q, seg_p_q});
    idx        = 2'd0;
    cnt_d      = 8'd0;
    captured_d = 1'b0;
    capture_o  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!an_q[i]) idx = 2'(i);
    end
    // Any change or an invalid select restarts settling and re-arms capture.
    if (sel_ok && same) begin
      cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
      captured_d = captured_q;
      if (cnt_d == CNT_MAX && !captured_q) begin
        capture_o  = 1'b1;
        captured_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q       <= 4'hF;
      seg_q      <= 8'hFF;
      an_p_q     <= 4'hF;
      seg_p_q    <= 8'hFF;
      cnt_q      <= 8'd0;
      captured_q <= 1'b0;
    end else begin
      an_q       <= an_i;
      seg_q      <= segment_i;
      an_p_q     <= an_q;
      seg_p_q    <= seg_q;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
    end
  end

  assign digit_idx_o = idx;
  assign seg_o       = seg_q[6:0];

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 4-digit value shown on a multiplexed seven-segment bus; frame_valid pulses on each full frame.
// Build option SEG_DEC_HEX_EN (in seg_pkg) makes A-F glyphs decode without raising code_err.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  segment,
  input  logic [3:0]  an,
  input  logic        clr_err,
  output logic [15:0] value,
  output logic [3:0]  digit_seen,
  output logic        frame_valid,
  output logic        code_err
);

  logic       cap;
  logic [1:0] cap_idx;
  logic [6:0] cap_seg;
  logic [4:0] dec;

  logic [15:0] shadow_q, shadow_d;
  logic [15:0] value_q, value_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic        fv_q, fv_d;
  logic        err_q, err_d;

  seg_settle #(.STABLE_CYCLES(STABLE_CYCLES)) u_settle (
    .clk         (clk),
    .rst         (rst),
    .segment_i   (segment),
    .an_i        (an),
    .capture_o   (cap),
    .digit_idx_o (cap_idx),
    .seg_o       (cap_seg)
  );

  always_comb begin
    dec      = seg_to_nibble(cap_seg);
    shadow_d = shadow_q;
    seen_d   = seen_q;
    value_d  = value_q;
    fv_d     = 1'b0;
    err_d    = err_q;
    if (clr_err) err_d = 1'b0;
    if (cap) begin
      shadow_d[{cap_idx, 2'b00} +: 4] = dec[3:0];
      seen_d = seen_q | (4'b0001 << cap_idx);
      if (!dec[4]) err_d = 1'b1;
      // The completing capture publishes straight from the updated shadow.
      if (seen_d == 4'hF) begin
        value_d = shadow_d;
        fv_d    = 1'b1;
        seen_d  = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= 16'h0000;
      value_q  <= 16'h0000;
      seen_q   <= 4'h0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      value_q  <= value_d;
      seen_q   <= seen_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  assign value       = value_q;
  assign digit_seen  = seen_q;
  assign frame_valid = fv_q;
  assign code_err    = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: expected frames are queued as scans are driven and popped on frame_valid.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  segment = 8'hFF;
  logic [3:0]  an = 4'hF;
  logic        clr_err = 1'b0;
  logic [15:0] value;
  logic [3:0]  digit_seen;
  logic        frame_valid;
  logic        code_err;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  int fv_base;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .segment     (segment),
    .an          (an),
    .clr_err     (clr_err),
    .value       (value),
    .digit_seen  (digit_seen),
    .frame_valid (frame_valid),
    .code_err    (code_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Active-low glyphs, g..a; index 16 is a blank digit.
  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
      3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
     12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;
     15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic show(input logic [3:0] an_v, input logic [7:0] seg_v, input int cycles);
    @(posedge clk); #1;
    an = an_v;
    segment = seg_v;
    repeat (cycles - 1) @(posedge clk);
  endtask

  task automatic dig(input int pos, input int d, input int cycles);
    logic [3:0] sel;
    sel = ~(4'b0001 << pos);
    show(sel, {1'b1, glyph(d)}, cycles);
  endtask

  task automatic idle(input int cycles);
    show(4'hF, 8'hFF, cycles);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    an = 4'hF;
    segment = 8'hFF;
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst === 1'b0 && frame_valid === 1'b1) begin
      fv_count++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL frame_extra: observed value %h with no expected frame queued", value);
      end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check("frame_value", value, exp_v);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_value", value, 16'h0000);
    check("rst_seen", digit_seen, 4'h0);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_err", code_err, 1'b0);
    rst = 1'b0;

    // 1234, 8 cycles per digit
    fv_base = fv_count;
    exp_q.push_back(16'h1234);
    dig(0, 4, 8);
    dig(1, 3, 8);
    dig(2, 2, 8);
    @(negedge clk);
    check("t1_seen_partial", digit_seen, 4'b0111);
    dig(3, 1, 8);
    idle(6);
    @(negedge clk);
    check("t1_fv_count", fv_count - fv_base, 1);
    check("t1_value", value, 16'h1234);
    check("t1_seen_clear", digit_seen, 4'h0);
    check("t1_err", code_err, 1'b0);

    // Too short to settle
    fv_base = fv_count;
    for (int i = 0; i < 4; i++) dig(i, 5 + i, 3);
    idle(10);
    @(negedge clk);
    check("t2_seen", digit_seen, 4'h0);
    check("t2_fv_count", fv_count - fv_base, 0);
    check("t2_value", value, 16'h1234);

    // Blank on digit 2 -> nibble F and sticky error
    exp_q.push_back(16'h1F34);
    dig(0, 4, 8);
    dig(1, 3, 8);
    dig(2, 16, 8);
    dig(3, 1, 8);
    idle(6);
    @(negedge clk);
    check("t3_err_set", code_err, 1'b1);
    check("t3_value", value, 16'h1F34);
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("t3_err_cleared", code_err, 1'b0);
    // clr_err coincides with an invalid capture (5th edge after pins change)
    @(posedge clk); #1;
    an = 4'b1110;
    segment = 8'hFF;
    repeat (4) @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("t3_err_set_wins", code_err, 1'b1);
    check("t3_seen_capture", digit_seen, 4'b0001);

    // Invalid selects, then one long hold
    do_reset();
    fv_base = fv_count;
    show(4'b1100, {1'b1, glyph(1)}, 20);
    show(4'b1111, {1'b1, glyph(1)}, 20);
    @(negedge clk);
    check("t4_no_capture", digit_seen, 4'h0);
    dig(0, 7, 50);
    @(negedge clk);
    check("t4_single_capture", digit_seen, 4'b0001);
    check("t4_fv_count", fv_count - fv_base, 0);

    // Async reset mid-frame, then a clean 5678 frame
    do_reset();
    exp_q.push_back(16'h1234);
    dig(0, 4, 8);
    dig(1, 3, 8);
    dig(2, 2, 8);
    dig(3, 1, 8);
    dig(0, 8, 8);
    dig(1, 16, 8);
    @(negedge clk);
    check("t5_seen_pre", digit_seen, 4'b0011);
    check("t5_value_pre", value, 16'h1234);
    check("t5_err_pre", code_err, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_value", value, 16'h0000);
    check("t5_async_seen", digit_seen, 4'h0);
    check("t5_async_fv", frame_valid, 1'b0);
    check("t5_async_err", code_err, 1'b0);
    an = 4'hF;
    segment = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(4);
    @(negedge clk);
    check("t5_value_hold", value, 16'h0000);
    exp_q.push_back(16'h5678);
    dig(0, 8, 8);
    dig(1, 7, 8);
    dig(2, 6, 8);
    dig(3, 5, 8);
    idle(6);
    @(negedge clk);
    check("t5_value", value, 16'h5678);
    check("t5_err", code_err, 1'b0);

    // Hex glyphs ABCD
    do_reset();
`ifdef SEG_DEC_HEX_EN
    exp_q.push_back(16'hABCD);
`else
    exp_q.push_back(16'hFFFF);
`endif
    dig(0, 13, 8);
    dig(1, 12, 8);
    dig(2, 11, 8);
    dig(3, 10, 8);
    idle(6);
    @(negedge clk);
`ifdef SEG_DEC_HEX_EN
    check("t6_value", value, 16'hABCD);
    check("t6_err", code_err, 1'b0);
`else
    check("t6_value", value, 16'hFFFF);
    check("t6_err", code_err, 1'b1);
`endif

    check("frames_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
